spell_wb_host: RTL and testbench
================================

Name: spell_wb_host

Overview:
Wishbone classic initiator that drives the spell core's register slave on behalf of a simple command/response stream from a debug UART bridge or test harness.
Each command becomes one single-beat Wishbone transaction: read, write, or poll-until-clear.
The block owns bus timing, the inter-transaction idle gap, the ack timeout and the poll loop, so upstream logic never sees raw Wishbone.

Parameters:
BASE_ADDR, 32'h3000_0000, OR-ed with cmd_addr to form o_wb_addr
TIMEOUT_CYCLES, 16, maximum cycles stb may stay high waiting for ack (range 1..255)
POLL_LIMIT, 255, maximum reads in one poll command (range 1..255)
POLL_GAP, 4, idle cycles between poll reads (range 1..15)

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-low; low forces reset immediately
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&&ready at posedge
cmd_op  in  2  0=read, 1=write, 2=poll, 3=illegal
cmd_addr  in  24  register offset (0x000..0x018 for spell)
cmd_data  in  32  write data (write) or bit mask (poll)
rsp_valid  out  1  response present; held until taken
rsp_ready  in  1  response taken when valid&&ready at posedge
rsp_data  out  32  read data, or 0 for writes, timeouts and illegal ops
rsp_err  out  1  timeout, poll exhausted, or illegal op
busy  out  1  high in any state other than IDLE
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  strobe (always equal to o_wb_cyc)
o_wb_we  out  1  write enable
o_wb_addr  out  32  address
o_wb_data  out  32  write data
i_wb_ack  in  1  slave ack
i_wb_data  in  32  slave read data

Behaviour:
- All outputs are registered. Reset (reset=0) immediately drives all outputs to 0; state=IDLE.
- Mid-transaction reset drops cyc/stb asynchronously and loses the command with no response.
- States: IDLE, BUS, GAP, RESP.
- IDLE: cmd_ready=1.
  - On accept of op 0/1/2: latch op, addr and data; cyc=stb=1; we=(op==1); addr=BASE_ADDR|{8'b0,cmd_addr}; o_wb_data=cmd_data (0 for read/poll); timeout counter=0; poll count=1; go to BUS.
  - On accept of op 3: go straight to RESP with err=1, data=0.
- BUS: cmd_ready=0.
  - If i_wb_ack=1: drop cyc/stb/we at that same edge and capture i_wb_data.
    - read: RESP, data=captured, err=0.
    - write: RESP, data=0, err=0.
    - poll with (captured & mask)==0: RESP, data=captured, err=0.
    - poll, mask not clear, count==POLL_LIMIT: RESP, data=captured, err=1.
    - otherwise poll: GAP.
  - Else if counter==TIMEOUT_CYCLES-1: drop cyc/stb, RESP with err=1, data=0. Otherwise counter+1.
- GAP: bus idle for POLL_GAP cycles, then re-issue the same read, count+1, counter=0, back to BUS.
- RESP: rsp_valid=1 with data/err stable until rsp_valid&&rsp_ready, then IDLE.
  - A command cannot be accepted in that same cycle, which guarantees at least 2 bus-idle cycles between transactions.
- i_wb_ack is ignored whenever stb=0. The spell slave holds ack one cycle past stb fall, and that stale ack must not complete the next transaction.
- Exactly one stb-high window per write. The spell stack-push register relies on an idle cycle between writes.
- Latency against a 1-cycle-ack slave: cmd accept edge N; stb high after N; ack sampled at N+2; rsp_valid high after N+2.
- Poll count: 8-bit. Timeout counter: 8-bit. No wrap is possible given the parameter ranges.

Test Plan:
- Read, slave acks 1 cycle after stb with 0x0000_0005: cmd op=0 addr=0x004 -> o_wb_addr=0x3000_0004, we=0; stb high exactly 2 cycles; rsp_data=0x5, err=0; rsp_valid 2 cycles after accept.
- Write then push: op=1 addr=0x018 data=0x41, then again data=0x42 -> two separate stb windows, each with we=1, separated by ≥2 idle cycles; both responses data=0, err=0.
- Timeout: slave never acks -> stb high exactly 16 cycles, then cyc/stb low; rsp_err=1, rsp_data=0; the next command works normally.
- Poll success: op=2 addr=0x00c mask=0x1; slave returns 1,1,0 -> 3 reads, each separated by 4 idle cycles; rsp_data=0, err=0.
- Poll exhaust with POLL_LIMIT=3: slave always returns 1 -> exactly 3 reads; err=1, rsp_data=1. Illegal op=3 -> no bus activity; err=1.
- Back-pressure and reset: hold rsp_ready=0 for 10 cycles -> rsp_valid/data stable and cmd_ready=0; pull reset low while stb=1 -> cyc/stb=0 before the next clock edge; after release, busy=0 and cmd_ready=1.

Source files
------------

// File: rtl/spell_wb_host.sv
// Wishbone classic initiator for the spell register slave: turns read/write/poll commands into
// single-beat bus transactions with ack timeout, poll loop and a registered response stream.
module spell_wb_host #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned POLL_LIMIT     = 255,
  parameter int unsigned POLL_GAP       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {StIdle, StBus, StGap, StResp} state_e;

  localparam logic [1:0] OpRead    = 2'd0;
  localparam logic [1:0] OpWrite   = 2'd1;
  localparam logic [1:0] OpPoll    = 2'd2;
  localparam logic [1:0] OpIllegal = 2'd3;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT);
  localparam logic [3:0] GAP_LAST  = 4'(POLL_GAP - 1);

  state_e      r_state, w_state;
  logic [1:0]  r_op, w_op;
  logic [31:0] r_mask, w_mask;
  logic [7:0]  r_to_cnt, w_to_cnt;
  logic [7:0]  r_poll_cnt, w_poll_cnt;
  logic [3:0]  r_gap_cnt, w_gap_cnt;
  logic        r_cmd_ready, w_cmd_ready;
  logic        r_rsp_valid, w_rsp_valid;
  logic [31:0] r_rsp_data, w_rsp_data;
  logic        r_rsp_err, w_rsp_err;
  logic        r_busy, w_busy;
  logic        r_cyc, w_cyc;
  logic        r_we, w_we;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;

  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_mask      = r_mask;
    w_to_cnt    = r_to_cnt;
    w_poll_cnt  = r_poll_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_err   = r_rsp_err;
    w_cyc       = r_cyc;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;

    unique case (r_state)
      StIdle: begin
        if (cmd_valid && r_cmd_ready) begin
          if (cmd_op == OpIllegal) begin
            w_state     = StResp;
            w_rsp_valid = 1'b1;
            w_rsp_data  = '0;
            w_rsp_err   = 1'b1;
          end else begin
            w_state    = StBus;
            w_op       = cmd_op;
            w_mask     = cmd_data;
            w_cyc      = 1'b1;
            w_we       = (cmd_op == OpWrite);
            w_addr     = BASE_ADDR | {8'b0, cmd_addr};
            w_wdata    = (cmd_op == OpWrite) ? cmd_data : '0;
            w_to_cnt   = '0;
            w_poll_cnt = 8'd1;
          end
        end
      end

      StBus: begin
        // Ack only counts while the strobe is up; the slave's trailing ack is stale.
        if (i_wb_ack && r_cyc) begin
          w_cyc = 1'b0;
          w_we  = 1'b0;
          unique case (r_op)
            OpWrite: begin
              w_state     = StResp;
              w_rsp_valid = 1'b1;
              w_rsp_data  = '0;
              w_rsp_err   = 1'b0;
            end
            OpPoll: begin
              if ((i_wb_data & r_mask) == '0 || r_poll_cnt == POLL_LAST) begin
                w_state     = StResp;
                w_rsp_valid = 1'b1;
                w_rsp_data  = i_wb_data;
                w_rsp_err   = ((i_wb_data & r_mask) != '0);
              end else begin
                w_state   = StGap;
                w_gap_cnt = '0;
              end
            end
            default: begin
              w_state     = StResp;
              w_rsp_valid = 1'b1;
              w_rsp_data  = i_wb_data;
              w_rsp_err   = 1'b0;
            end
          endcase
        end else if (r_to_cnt == TO_LAST) begin
          w_cyc       = 1'b0;
          w_we        = 1'b0;
          w_state     = StResp;
          w_rsp_valid = 1'b1;
          w_rsp_data  = '0;
          w_rsp_err   = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + 8'd1;
        end
      end

      StGap: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state    = StBus;
          w_cyc      = 1'b1;
          w_poll_cnt = r_poll_cnt + 8'd1;
          w_to_cnt   = '0;
        end else begin
          w_gap_cnt = r_gap_cnt + 4'd1;
        end
      end

      StResp: begin
        if (r_rsp_valid && rsp_ready) begin
          w_state     = StIdle;
          w_rsp_valid = 1'b0;
        end
      end

      default: w_state = StIdle;
    endcase

    w_cmd_ready = (w_state == StIdle);
    w_busy      = (w_state != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_op        <= OpRead;
      r_mask      <= '0;
      r_to_cnt    <= '0;
      r_poll_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_mask      <= w_mask;
      r_to_cnt    <= w_to_cnt;
      r_poll_cnt  <= w_poll_cnt;
      r_gap_cnt   <= w_gap_cnt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_err   <= w_rsp_err;
      r_busy      <= w_busy;
      r_cyc       <= w_cyc;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_cyc;
  assign o_wb_we   = r_we;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_wdata;

endmodule

// File: tb/tb_spell_wb_host.sv
// Scoreboard bench for spell_wb_host: directed commands against a spell-like slave that acks
// one cycle after stb and holds ack one cycle past stb fall.
module tb_spell_wb_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [23:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic        wb_ack;

  spell_wb_host #(
    .BASE_ADDR     (32'h3000_0000),
    .TIMEOUT_CYCLES(16),
    .POLL_LIMIT    (3),
    .POLL_GAP      (4)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .o_wb_cyc (wb_cyc),
    .o_wb_stb (wb_stb),
    .o_wb_we  (wb_we),
    .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata),
    .i_wb_ack (wb_ack),
    .i_wb_data(wb_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Slave model
  logic        slv_en = 1'b1;
  logic [31:0] slv_data [8];
  int unsigned slv_cnt = 0;
  int unsigned slv_mark = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_ack <= 1'b0;
    else        wb_ack <= wb_stb && slv_en;
  end
  always @(posedge clk) if (wb_stb && wb_ack) slv_cnt <= slv_cnt + 1;
  assign wb_rdata = slv_data[3'(slv_cnt - slv_mark)];

  // Response scoreboard
  typedef struct {logic [31:0] data; logic err;} rsp_t;
  rsp_t sb_q[$];

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin : mon
      rsp_t e;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %b, required no response", rsp_data, rsp_err);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Bus window monitor
  int          win_len[$], win_gap[$];
  logic        win_we[$];
  logic [31:0] win_addr[$], win_wdata[$];
  int          cur_len = 0, idle_len = 100;
  logic        prev_stb = 1'b0, f_we = 1'b0;
  logic [31:0] f_addr = '0, f_wdata = '0;

  always @(negedge clk) begin
    if (wb_stb) begin
      if (!prev_stb) begin
        win_gap.push_back(idle_len);
        f_we    = wb_we;
        f_addr  = wb_addr;
        f_wdata = wb_wdata;
        cur_len = 0;
      end
      cur_len++;
    end else begin
      if (prev_stb) begin
        win_len.push_back(cur_len);
        win_we.push_back(f_we);
        win_addr.push_back(f_addr);
        win_wdata.push_back(f_wdata);
        idle_len = 0;
      end
      idle_len++;
    end
    prev_stb = wb_stb;
  end

  task automatic check_win(input string name, input int len, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gmin, input int gmax);
    int g;
    if (win_len.size() == 0 || win_gap.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_window: got no stb window, required one", name);
    end else begin
      g = win_gap.pop_front();
      chk({name, "_len"}, 32'(win_len.pop_front()), 32'(len));
      chk({name, "_we"}, {31'b0, win_we.pop_front()}, {31'b0, we});
      chk({name, "_addr"}, win_addr.pop_front(), addr);
      chk({name, "_wdata"}, win_wdata.pop_front(), wdata);
      chk({name, "_gap_in_range"}, {31'b0, (g >= gmin && g <= gmax)}, 32'd1);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    sb_q.push_back(r);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
    bit ok = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got cmd_ready low for 100 cycles, required accept");
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL rsp_wait: got no rsp_valid in 200 cycles, required a response");
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) slv_data[i] = '0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctl", {25'b0, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, busy, cmd_ready}, 32'd0);
    chk("reset_addr", wb_addr, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Read
    slv_mark = slv_cnt;
    slv_data[0] = 32'h0000_0005;
    expect_rsp(32'h5, 1'b0);
    send_cmd(2'd0, 24'h000004, 32'hdead_beef);
    wait_rsp(n);
    chk("read_latency", 32'(n), 32'd3);
    @(negedge clk);
    check_win("read", 2, 1'b0, 32'h3000_0004, 32'h0, 0, 100000);

    // Two pushes
    expect_rsp(32'h0, 1'b0);
    send_cmd(2'd1, 24'h000018, 32'h41);
    wait_rsp(n);
    @(negedge clk);
    check_win("push1", 2, 1'b1, 32'h3000_0018, 32'h41, 2, 100000);
    expect_rsp(32'h0, 1'b0);
    send_cmd(2'd1, 24'h000018, 32'h42);
    wait_rsp(n);
    @(negedge clk);
    check_win("push2", 2, 1'b1, 32'h3000_0018, 32'h42, 2, 100000);

    // Timeout, then recovery
    slv_en = 1'b0;
    expect_rsp(32'h0, 1'b1);
    send_cmd(2'd0, 24'h000008, 32'h0);
    wait_rsp(n);
    chk("timeout_latency", 32'(n), 32'd17);
    @(negedge clk);
    check_win("timeout", 16, 1'b0, 32'h3000_0008, 32'h0, 2, 100000);
    slv_en = 1'b1;
    slv_mark = slv_cnt;
    slv_data[0] = 32'h7;
    expect_rsp(32'h7, 1'b0);
    send_cmd(2'd0, 24'h000000, 32'h0);
    wait_rsp(n);
    @(negedge clk);
    check_win("after_to", 2, 1'b0, 32'h3000_0000, 32'h0, 2, 100000);

    // Poll clears on third read
    slv_mark = slv_cnt;
    slv_data[0] = 32'h1;
    slv_data[1] = 32'h1;
    slv_data[2] = 32'h0;
    expect_rsp(32'h0, 1'b0);
    send_cmd(2'd2, 24'h00000c, 32'h1);
    wait_rsp(n);
    @(negedge clk);
    check_win("poll1", 2, 1'b0, 32'h3000_000c, 32'h0, 2, 100000);
    check_win("poll2", 2, 1'b0, 32'h3000_000c, 32'h0, 4, 4);
    check_win("poll3", 2, 1'b0, 32'h3000_000c, 32'h0, 4, 4);

    // Poll exhausts at the limit of 3
    slv_mark = slv_cnt;
    for (int i = 0; i < 8; i++) slv_data[i] = 32'h1;
    expect_rsp(32'h1, 1'b1);
    send_cmd(2'd2, 24'h00000c, 32'h1);
    wait_rsp(n);
    repeat (8) @(negedge clk);
    check_win("exh1", 2, 1'b0, 32'h3000_000c, 32'h0, 2, 100000);
    check_win("exh2", 2, 1'b0, 32'h3000_000c, 32'h0, 4, 4);
    check_win("exh3", 2, 1'b0, 32'h3000_000c, 32'h0, 4, 4);
    chk("exh_read_count", 32'(win_gap.size()), 32'd0);

    // Illegal op
    expect_rsp(32'h0, 1'b1);
    send_cmd(2'd3, 24'h000004, 32'h0);
    wait_rsp(n);
    chk("illegal_latency", 32'(n), 32'd1);
    repeat (4) @(negedge clk);
    chk("illegal_no_bus", 32'(win_gap.size() + win_len.size()), 32'd0);

    // Back-pressure
    slv_mark = slv_cnt;
    slv_data[0] = 32'h9;
    rsp_ready = 1'b0;
    expect_rsp(32'h9, 1'b0);
    send_cmd(2'd0, 24'h000010, 32'h0);
    wait_rsp(n);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", {30'b0, rsp_valid, cmd_ready}, 32'd2);
      chk("bp_data", rsp_data, 32'h9);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_win("bp", 2, 1'b0, 32'h3000_0010, 32'h0, 2, 100000);

    // Reset while stb is high; command is dropped without a response
    slv_en = 1'b0;
    send_cmd(2'd0, 24'h000004, 32'h0);
    @(negedge clk);
    chk("pre_reset_stb", {31'b0, wb_stb}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_drops_bus", {29'b0, wb_cyc, wb_stb, busy}, 32'd0);
    chk("reset_drops_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {30'b0, busy, cmd_ready}, 32'd1);
    win_len.delete();
    win_gap.delete();
    win_we.delete();
    win_addr.delete();
    win_wdata.delete();
    slv_en = 1'b1;
    slv_mark = slv_cnt;
    slv_data[0] = 32'h1234;
    expect_rsp(32'h1234, 1'b0);
    send_cmd(2'd0, 24'h000014, 32'h0);
    wait_rsp(n);
    @(negedge clk);
    check_win("post_reset", 2, 1'b0, 32'h3000_0014, 32'h0, 2, 100000);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
